instruction_fetch_unit: RTL and testbench

//  Front end of the XM multi-cycle core: fetches 16-bit instruction words from memory and drives the decoder's inst_data input.

---
 rtl/instruction_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding memory read, valid/ready hand-off to decode.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module instruction_fetch_unit #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-2){1'b0}}, 2'b10};

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   pc_r, pc_s;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                mem_rd_r, mem_rd_s;
  logic                discard_r, discard_s;
  logic [DATA_W-1:0]   inst_data_r, inst_data_s;
  logic [ADDR_W-1:0]   inst_pc_r, inst_pc_s;
  logic                inst_valid_r, inst_valid_s;

  // Next-state, next-PC and output-register decode for the fetch FSM.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    mem_rd_s     = 1'b0;
    discard_s    = discard_r;
    inst_data_s  = inst_data_r;
    inst_pc_s    = inst_pc_r;
    inst_valid_s = inst_valid_r;

    case (state_r)
      IDLE: begin
        if (en) begin
          state_s  = REQ;
          mem_rd_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      REQ: begin
        if (discard_r) begin
          // A redirected request is still owed one response; swallow it, then reissue.
          if (mem_rdy) begin
            discard_s = 1'b0;
            if (en) begin
              mem_rd_s = 1'b1;
            end else begin
              state_s  = IDLE;
            end
          end else begin
            mem_rd_s = 1'b0;
          end
        end else if (pc_ld) begin
          if (mem_rdy) begin
            mem_rd_s = 1'b1;
          end else begin
            discard_s = 1'b1;
          end
        end else if (mem_rdy) begin
          inst_data_s  = mem_data;
          inst_pc_s    = mem_addr_r;
          inst_valid_s = 1'b1;
          pc_s         = pc_r + PC_STEP;
          state_s      = HOLD;
        end else begin
          mem_rd_s = 1'b1;
        end
      end
      HOLD: begin
        if (pc_ld || (inst_valid_r && inst_ready)) begin
          inst_valid_s = 1'b0;
          if (en) begin
            state_s  = REQ;
            mem_rd_s = 1'b1;
          end else begin
            state_s  = IDLE;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s      = IDLE;
        discard_s    = 1'b0;
        inst_valid_s = 1'b0;
      end
    endcase

    if (pc_ld) begin
      pc_s = pc_in & ALIGN_MASK;
    end else begin
      pc_s = pc_s;
    end
  end

  // State and output registers; mem_addr shadows the PC so it is stable across a request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pc_r         <= RESET_VECTOR & ALIGN_MASK;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_rd_r     <= 1'b0;
      discard_r    <= 1'b0;
      inst_data_r  <= {DATA_W{1'b0}};
      inst_pc_r    <= {ADDR_W{1'b0}};
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      mem_addr_r   <= pc_s;
      mem_rd_r     <= mem_rd_s;
      discard_r    <= discard_s;
      inst_data_r  <= inst_data_s;
      inst_pc_r    <= inst_pc_s;
      inst_valid_r <= inst_valid_s;
    end
  end

  assign pc         = pc_r;
  assign mem_addr   = mem_addr_r;
  assign mem_rd     = mem_rd_r;
  assign inst_data  = inst_data_r;
  assign inst_pc    = inst_pc_r;
  assign inst_valid = inst_valid_r;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_r;
  logic [15:0] stall_cnt_r;

  // Delivered-word and memory-wait counters, both free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_r <= 16'h0000;
      stall_cnt_r <= 16'h0000;
    end else begin
      if (inst_valid_r && inst_ready) begin
        fetch_cnt_r <= fetch_cnt_r + 16'h0001;
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      if ((state_r == REQ) && !mem_rdy) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_r;
  assign stall_cnt = stall_cnt_r;
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized
// fetch traffic against a memory responder and an expected-address-sequence model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, en, mem_rdy, inst_ready, pc_ld;
  logic        mem_rd, inst_valid;
  logic [15:0] mem_addr, mem_data, inst_data, inst_pc, pc_in, pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt;
`endif

  int          n_checks;
  int          n_fail;
  logic [15:0] mem [0:32767];
  int          wait_cfg;
  bit          rand_wait;
  bit          busy;
  int          cnt;
  logic [15:0] req_addr;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .en(en),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdy(mem_rdy), .mem_data(mem_data),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc_ld(pc_ld), .pc_in(pc_in), .pc(pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One clock step; the memory responder serves one request at a time after a wait.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (reset) begin
      busy    = 1'b0;
      mem_rdy = 1'b0;
    end else begin
      if (busy && mem_rd) begin
        n_checks++;
        if (mem_addr !== req_addr) begin
          n_fail++;
          $display("FAIL mem_addr_stable: got %h want %h", mem_addr, req_addr);
        end
      end
      if (!busy && mem_rd) begin
        busy     = 1'b1;
        req_addr = mem_addr;
        cnt      = rand_wait ? int'($urandom_range(3, 0)) : wait_cfg;
      end
      if (busy && cnt == 0) begin
        mem_rdy  = 1'b1;
        mem_data = mem[req_addr[15:1]];
        busy     = 1'b0;
      end else begin
        mem_rdy  = 1'b0;
        mem_data = 16'($urandom);
        if (busy) cnt--;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; inst_ready = 1'b0; pc_ld = 1'b0; pc_in = 16'h0000;
    rand_wait = 1'b0; wait_cfg = 0;
    cycle();
    cycle();
    reset = 1'b0; busy = 1'b0; mem_rdy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", pc); end
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", inst_data); end
    n_checks++; if (inst_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0000", inst_pc); end
`ifdef FETCH_PERF_CNT_EN
    n_checks++; if (fetch_cnt !== 16'h0000 || stall_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h want 0000/0000", fetch_cnt, stall_cnt); end
`endif
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [2];
    int k;
    int first_i;
    exp_d[0] = 16'h4254; exp_d[1] = 16'h1FFE;
    do_reset();
    en = 1'b1; inst_ready = 1'b1; k = 0; first_i = -1;
    for (int i = 0; i < 20 && k < 2; i++) begin
      cycle();
      if (inst_valid && inst_ready) begin
        if (k == 0) first_i = i;
        n_checks++; if (inst_pc !== 16'(k * 2)) begin n_fail++; $display("FAIL basic_inst_pc%0d: got %h want %h", k, inst_pc, 16'(k * 2)); end
        n_checks++; if (inst_data !== exp_d[k]) begin n_fail++; $display("FAIL basic_data%0d: got %h want %h", k, inst_data, exp_d[k]); end
        if (k == 1) begin
          n_checks++; if (pc !== 16'h0004) begin n_fail++; $display("FAIL basic_pc: got %h want 0004", pc); end
          en = 1'b0;
        end
        k++;
      end
    end
    n_checks++; if (k != 2) begin n_fail++; $display("FAIL basic_timeout: got %0d words want 2", k); end
    n_checks++; if (first_i != 1) begin n_fail++; $display("FAIL basic_latency: got cycle %0d want 1", first_i); end
  endtask

  task automatic test_wait();
    int nrd;
    bit seen;
    do_reset();
    wait_cfg = 3; en = 1'b1; inst_ready = 1'b0; nrd = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (inst_valid) seen = 1'b1;
      else if (mem_rd) nrd++;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL wait_timeout: no inst_valid"); end
    n_checks++; if (nrd != 4) begin n_fail++; $display("FAIL wait_rd_cycles: got %0d want 4", nrd); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++; if (inst_valid !== 1'b1 || inst_data !== mem[0]) begin
        n_fail++; $display("FAIL wait_hold: got %b/%h want 1/%h", inst_valid, inst_data, mem[0]); end
    end
    inst_ready = 1'b1; en = 1'b0;
    cycle();
    inst_ready = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL wait_one_transfer: got %b want 0", inst_valid); end
    cycle();
    n_checks++; if (mem_rd !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL wait_idle: got rd=%b valid=%b want 0/0", mem_rd, inst_valid); end
  endtask

  task automatic test_redirect();
    bit          seen;
    bit          got_addr;
    do_reset();
    wait_cfg = 3; en = 1'b1; inst_ready = 1'b1;
    cycle();
    pc_ld = 1'b1; pc_in = 16'h0101; wait_cfg = 1;
    cycle();
    pc_ld = 1'b0;
    n_checks++; if (pc !== 16'h0100 || mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL redir_drop: got pc=%h rd=%b want 0100/0", pc, mem_rd); end
    seen = 1'b0; got_addr = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (mem_rd && !got_addr) begin
        got_addr = 1'b1;
        n_checks++; if (mem_addr !== 16'h0100) begin n_fail++; $display("FAIL redir_mem_addr: got %h want 0100", mem_addr); end
      end
      if (inst_valid) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL redir_timeout: no inst_valid"); end
    n_checks++; if (inst_pc !== 16'h0100 || inst_data !== mem[16'h0080]) begin
      n_fail++; $display("FAIL redir_word: got %h@%h want %h@0100", inst_data, inst_pc, mem[16'h0080]); end
    en = 1'b0;
  endtask

  task automatic test_hold_redirect();
    bit seen;
    do_reset();
    en = 1'b1; inst_ready = 1'b0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (inst_valid) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL hold_timeout: no first word"); end
    inst_ready = 1'b1; pc_ld = 1'b1; pc_in = 16'h2468;
    n_checks++; if (inst_pc !== 16'h0000 || inst_data !== mem[0]) begin
      n_fail++; $display("FAIL hold_old_word: got %h@%h want %h@0000", inst_data, inst_pc, mem[0]); end
    cycle();
    pc_ld = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || pc !== 16'h2468 || mem_rd !== 1'b1 || mem_addr !== 16'h2468) begin
      n_fail++; $display("FAIL hold_redir: got v=%b pc=%h rd=%b a=%h want 0/2468/1/2468", inst_valid, pc, mem_rd, mem_addr); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (inst_valid) seen = 1'b1;
    end
    n_checks++; if (!seen || inst_pc !== 16'h2468 || inst_data !== mem[16'h1234]) begin
      n_fail++; $display("FAIL hold_new_word: got %h@%h want %h@2468", inst_data, inst_pc, mem[16'h1234]); end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset();
    pc_ld = 1'b1; pc_in = 16'hFFFF;
    cycle();
    pc_ld = 1'b0;
    n_checks++; if (pc !== 16'hFFFE || mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL wrap_load: got pc=%h rd=%b want FFFE/0", pc, mem_rd); end
    en = 1'b1; inst_ready = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (inst_valid && inst_ready) begin
        seen = 1'b1;
        en = 1'b0;
        n_checks++; if (inst_pc !== 16'hFFFE || inst_data !== mem[16'h7FFF] || pc !== 16'h0000) begin
          n_fail++; $display("FAIL wrap_word: got %h@%h pc=%h want %h@FFFE pc=0000", inst_data, inst_pc, pc, mem[16'h7FFF]); end
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL wrap_timeout: no word"); end
    // reset in the middle of a waiting request
    do_reset();
    wait_cfg = 5; en = 1'b1; pc_ld = 1'b1; pc_in = 16'h3000;
    cycle();
    pc_ld = 1'b0; en = 1'b0;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h3000) begin
      n_fail++; $display("FAIL midreq_start: got rd=%b a=%h want 1/3000", mem_rd, mem_addr); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++; if (mem_rd !== 1'b0 || pc !== 16'h0000 || inst_valid !== 1'b0 || mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL midreq_reset: got rd=%b pc=%h v=%b a=%h want 0/0000/0/0000", mem_rd, pc, inst_valid, mem_addr); end
  endtask

  task automatic test_random();
    logic [15:0] exp_addr;
    logic [15:0] held_data;
    bit          held;
    int          ndel;
    do_reset();
    rand_wait = 1'b1; exp_addr = 16'h0000; held = 1'b0; ndel = 0;
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (held && inst_valid) begin
        n_checks++; if (inst_data !== held_data) begin n_fail++; $display("FAIL rand_hold: got %h want %h", inst_data, held_data); end
      end
      en = ($urandom_range(9, 0) != 0);
      inst_ready = 1'($urandom_range(1, 0));
      pc_ld = 1'b0;
      if (!mem_rd && !inst_valid && $urandom_range(7, 0) == 0) begin
        pc_ld = 1'b1;
        pc_in = 16'($urandom);
        exp_addr = pc_in & 16'hFFFE;
      end
      if (inst_valid && inst_ready) begin
        n_checks++; if (inst_pc !== exp_addr || inst_data !== mem[exp_addr[15:1]] || pc !== exp_addr + 16'h0002) begin
          n_fail++; $display("FAIL rand_word: got %h@%h pc=%h want %h@%h", inst_data, inst_pc, pc, mem[exp_addr[15:1]], exp_addr); end
        exp_addr = exp_addr + 16'h0002;
        ndel++;
      end
      held = inst_valid && !inst_ready;
      held_data = inst_data;
    end
    n_checks++; if (ndel < 20) begin n_fail++; $display("FAIL rand_progress: got %0d words want >=20", ndel); end
    en = 1'b0; pc_ld = 1'b0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    int k;
    do_reset();
    wait_cfg = 1; en = 1'b1; inst_ready = 1'b1; k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      cycle();
      if (inst_valid && inst_ready) begin
        k++;
        if (k == 4) en = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) cycle();
    n_checks++; if (fetch_cnt !== 16'd4 || stall_cnt !== 16'd4) begin
      n_fail++; $display("FAIL perf_counts: got %0d/%0d want 4/4", fetch_cnt, stall_cnt); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; en = 1'b0; mem_rdy = 1'b0; mem_data = 16'h0000;
    inst_ready = 1'b0; pc_ld = 1'b0; pc_in = 16'h0000;
    busy = 1'b0; cnt = 0; req_addr = 16'h0000; wait_cfg = 0; rand_wait = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h4254;
    mem[1] = 16'h1FFE;
    test_reset();
    test_basic();
    test_wait();
    test_redirect();
    test_hold_redirect();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
